// File: rtl/store_buffer_if.sv
// Store-buffer bus: producer store port, drain hold, load lookup,
// RAM write port and occupancy status.
interface store_buffer_if #(
    parameter int D_WIDTH = 19,
    parameter int A_WIDTH = 5,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic               st_valid;
    logic [A_WIDTH-1:0] st_address;
    logic [D_WIDTH-1:0] st_data;
    logic               st_ready;
    logic               drain_hold;
    logic [A_WIDTH-1:0] ld_address;
    logic               ld_hit;
    logic [D_WIDTH-1:0] ld_data;
    logic [A_WIDTH-1:0] ram_address_write;
    logic [D_WIDTH-1:0] ram_data_write;
    logic               ram_write_enable;
    logic               empty;
    logic [CW-1:0]      count;

    modport master (
        output st_valid, st_address, st_data, drain_hold, ld_address,
        input  st_ready, ld_hit, ld_data, ram_address_write, ram_data_write,
               ram_write_enable, empty, count
    );

    modport slave (
        input  st_valid, st_address, st_data, drain_hold, ld_address,
        output st_ready, ld_hit, ld_data, ram_address_write, ram_data_write,
               ram_write_enable, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer: circular FIFO draining one entry per cycle to RAM,
// with combinational youngest-match load forwarding.
module store_buffer #(
    parameter int D_WIDTH = 19,
    parameter int A_WIDTH = 5,
    parameter int DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int         PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [A_WIDTH-1:0] r_addr [DEPTH];
    logic [D_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [PW:0]        r_count;

    logic               w_empty;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [PW-1:0]      w_idx;
    logic               w_hit;
    logic [D_WIDTH-1:0] w_ld_data;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign w_empty = (r_count == '0);
    assign w_ready = (r_count != FULL);
    assign w_push  = sb.st_valid && w_ready;
    assign w_pop   = !w_empty && !sb.drain_hold;

    assign sb.st_ready         = w_ready;
    assign sb.empty            = w_empty;
    assign sb.count            = r_count;
    assign sb.ram_write_enable = w_pop;
    assign sb.ram_address_write = w_empty ? '0 : r_addr[r_head];
    assign sb.ram_data_write    = w_empty ? '0 : r_data[r_head];
    assign sb.ld_hit           = w_hit;
    assign sb.ld_data          = w_ld_data;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_hit     = 1'b0;
        w_ld_data = '0;
        w_idx     = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_valid[w_idx] && (r_addr[w_idx] == sb.ld_address)) begin
                w_hit     = 1'b1;
                w_ld_data = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            // Push and pop never share a slot: both imply 0 < count < DEPTH.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_addr[r_tail] <= sb.st_address;
            r_data[r_tail] <= sb.st_data;
        end
    end
endmodule
